// File: rtl/dcache_mem_responder_if.sv
// Line refill / write-back bus between the DCache (master) and its memory
// responder (slave). Member names mirror the responder's port list.
interface dcache_mem_responder_if;
  logic         mem_ren_i;
  logic [31:0]  mem_araddr_i;
  logic         mem_rvalid_o;
  logic [255:0] mem_rdata_o;
  logic         mem_wen_i;
  logic [31:0]  mem_awaddr_i;
  logic [255:0] mem_wdata_i;
  logic         mem_bvalid_o;
  logic         busy_o;
  logic [15:0]  rd_cnt_o;
  logic [15:0]  wr_cnt_o;

  modport master (
    output mem_ren_i, mem_araddr_i, mem_wen_i, mem_awaddr_i, mem_wdata_i,
    input  mem_rvalid_o, mem_rdata_o, mem_bvalid_o, busy_o, rd_cnt_o, wr_cnt_o
  );

  modport slave (
    input  mem_ren_i, mem_araddr_i, mem_wen_i, mem_awaddr_i, mem_wdata_i,
    output mem_rvalid_o, mem_rdata_o, mem_bvalid_o, busy_o, rd_cnt_o, wr_cnt_o
  );
endinterface

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for DCache line refills and dirty write-backs:
// one whole-line transaction at a time, fixed latencies, NLINES x 256-bit store.
module dcache_mem_responder #(
  parameter int IDX_W     = 6,
  parameter int READ_LAT  = 7,
  parameter int WRITE_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  dcache_mem_responder_if.slave  mem
);

  localparam int NLINES = 1 << IDX_W;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_WAIT = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;
  localparam logic [2:0] HOLD    = 3'd5;

  localparam logic [15:0] RD_LAT_M1 = 16'(READ_LAT - 1);
  localparam logic [15:0] WR_LAT_M1 = 16'(WRITE_LAT - 1);

  logic [2:0]       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [255:0]     wdata_q, wdata_d;
  logic [255:0]     rdata_q;
  logic             rvalid_q, bvalid_q;
  logic [15:0]      rd_cnt_q, wr_cnt_q;
  logic [NLINES-1:0] valid_q;

  logic [255:0] store [NLINES];

  logic enter_rd_resp;
  logic enter_wr_resp;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        // Write-back takes priority so a dirty victim lands before its refill.
        if (mem.mem_wen_i) begin
          idx_d   = mem.mem_awaddr_i[5+IDX_W-1:5];
          wdata_d = mem.mem_wdata_i;
          cnt_d   = WR_LAT_M1;
          state_d = (WRITE_LAT == 1) ? WR_RESP : WR_WAIT;
        end else if (mem.mem_ren_i) begin
          idx_d   = mem.mem_araddr_i[5+IDX_W-1:5];
          cnt_d   = RD_LAT_M1;
          state_d = (READ_LAT == 1) ? RD_RESP : RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = RD_RESP;
      end
      WR_WAIT: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = WR_RESP;
      end
      RD_RESP: state_d = HOLD;
      WR_RESP: state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_rd_resp = (state_d == RD_RESP);
  assign enter_wr_resp = (state_d == WR_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rvalid_q <= enter_rd_resp;
      bvalid_q <= enter_wr_resp;
      // Refill data is sampled once on entry to RD_RESP; never-written lines read as zero.
      if (enter_rd_resp) begin
        rdata_q <= valid_q[idx_d] ? store[idx_d] : '0;
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (enter_wr_resp) begin
        valid_q[idx_d] <= 1'b1;
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  // Data array carries no reset; the valid bits alone decide what a line reads as.
  always_ff @(posedge clk) begin
    if (enter_wr_resp && rst) store[idx_d] <= wdata_d;
  end

  assign mem.mem_rvalid_o = rvalid_q;
  assign mem.mem_rdata_o  = rdata_q;
  assign mem.mem_bvalid_o = bvalid_q;
  assign mem.busy_o       = (state_q != IDLE);
  assign mem.rd_cnt_o     = rd_cnt_q;
  assign mem.wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder: refill, write-back, priority,
// HOLD behaviour, index aliasing and asynchronous reset mid-transaction.
module tb_dcache_mem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dcache_mem_responder_if bus ();

  dcache_mem_responder #(.IDX_W(6), .READ_LAT(7), .WRITE_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .mem (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] D1 =
    256'h12345678_91023456_78910234_22222222_34567891_02345678_91023456_78910234;
  localparam logic [255:0] D2 =
    256'hA5A5A5A5_0F0F0F0F_DEADBEEF_CAFEF00D_01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [255:0] D3 =
    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [255:0] D4 =
    256'hFFFF0000_EEEE1111_DDDD2222_CCCC3333_BBBB4444_AAAA5555_99996666_88887777;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits on negedges until rvalid, returning how many negedges it took.
  task automatic wait_rvalid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.mem_rvalid_o && k < 40);
  endtask

  task automatic wait_bvalid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.mem_bvalid_o && k < 40);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [255:0] d,
                          input int exp_wr);
    int k;
    bus.mem_wen_i    = 1'b1;
    bus.mem_awaddr_i = a;
    bus.mem_wdata_i  = d;
    wait_bvalid(k);
    chk({tag, "_wlat"}, 256'(k), 256'(4));
    chk({tag, "_wrcnt"}, 256'(bus.wr_cnt_o), 256'(exp_wr));
    bus.mem_wen_i = 1'b0;
    @(negedge clk);
    chk({tag, "_bpulse"}, 256'(bus.mem_bvalid_o), 256'(0));
    @(negedge clk);
    chk({tag, "_idle"}, 256'(bus.busy_o), 256'(0));
    $display("write %s addr=%h wr_cnt=%0d", tag, a, bus.wr_cnt_o);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [255:0] exp,
                         input int exp_rd);
    int k;
    bus.mem_ren_i    = 1'b1;
    bus.mem_araddr_i = a;
    wait_rvalid(k);
    chk({tag, "_rlat"}, 256'(k), 256'(7));
    chk({tag, "_rdata"}, bus.mem_rdata_o, exp);
    chk({tag, "_rdcnt"}, 256'(bus.rd_cnt_o), 256'(exp_rd));
    bus.mem_ren_i = 1'b0;
    @(negedge clk);
    chk({tag, "_rpulse"}, 256'(bus.mem_rvalid_o), 256'(0));
    @(negedge clk);
    chk({tag, "_idle"}, 256'(bus.busy_o), 256'(0));
    $display("read  %s addr=%h rd_cnt=%0d", tag, a, bus.rd_cnt_o);
  endtask

  initial begin
    int k;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.mem_ren_i    = 1'b0;
    bus.mem_araddr_i = '0;
    bus.mem_wen_i    = 1'b0;
    bus.mem_awaddr_i = '0;
    bus.mem_wdata_i  = '0;
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 256'(bus.mem_rvalid_o), 256'(0));
    chk("rst_bvalid", 256'(bus.mem_bvalid_o), 256'(0));
    chk("rst_busy",   256'(bus.busy_o), 256'(0));
    chk("rst_rdata",  bus.mem_rdata_o, 256'h0);
    chk("rst_cnts",   256'({bus.rd_cnt_o, bus.wr_cnt_o}), 256'(0));
    rst = 1'b1;
    @(negedge clk);

    // Refill of a never-written line.
    do_read("cold", 32'h0000_D000, 256'h0, 1);

    // Write-back then refill of the same index with different offset bits.
    do_write("wb1", 32'h2468_7570, D1, 1);
    bus.mem_ren_i    = 1'b1;
    bus.mem_araddr_i = 32'h2468_7560;
    wait_rvalid(k);
    chk("raw_rlat", 256'(k), 256'(7));
    chk("raw_rdata", bus.mem_rdata_o, D1);
    chk("raw_word4", 256'(bus.mem_rdata_o[159:128]), 256'(32'h22222222));
    bus.mem_ren_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("read  raw addr=24687560 word4=%h", bus.mem_rdata_o[159:128]);

    // Simultaneous requests: write first, then the still-pending read.
    bus.mem_ren_i    = 1'b1;
    bus.mem_araddr_i = 32'h5968_7570;
    bus.mem_wen_i    = 1'b1;
    bus.mem_awaddr_i = 32'h1168_7570;
    bus.mem_wdata_i  = D2;
    wait_bvalid(k);
    chk("both_wlat", 256'(k), 256'(4));
    chk("both_wrcnt", 256'(bus.wr_cnt_o), 256'(2));
    chk("both_rdcnt_pre", 256'(bus.rd_cnt_o), 256'(2));
    chk("both_no_rvalid", 256'(bus.mem_rvalid_o), 256'(0));
    bus.mem_wen_i = 1'b0;
    @(negedge clk);
    chk("both_hold_busy", 256'(bus.busy_o), 256'(1));
    @(negedge clk);
    chk("both_idle", 256'(bus.busy_o), 256'(0));
    wait_rvalid(k);
    chk("both_rlat", 256'(k), 256'(7));
    chk("both_rdata", bus.mem_rdata_o, D2);
    chk("both_rdcnt", 256'(bus.rd_cnt_o), 256'(3));
    $display("both  wr_cnt=%0d rd_cnt=%0d", bus.wr_cnt_o, bus.rd_cnt_o);

    // Requester holds ren one cycle past rvalid: HOLD must swallow it.
    @(negedge clk);
    chk("hold_rvalid", 256'(bus.mem_rvalid_o), 256'(0));
    chk("hold_busy", 256'(bus.busy_o), 256'(1));
    bus.mem_ren_i = 1'b0;
    @(negedge clk);
    chk("hold_idle", 256'(bus.busy_o), 256'(0));
    @(negedge clk);
    chk("hold_still_idle", 256'(bus.busy_o), 256'(0));
    chk("hold_rdcnt", 256'(bus.rd_cnt_o), 256'(3));
    $display("hold  busy=%0d rd_cnt=%0d", bus.busy_o, bus.rd_cnt_o);

    // Upper address bits alias onto the same line.
    do_write("alias_w", 32'h0000_0040, D3, 3);
    do_read("alias_r", 32'h8000_0040, D3, 4);

    // Reset in the middle of a refill wait.
    do_write("pre_rst", 32'h0000_00A0, D4, 4);
    bus.mem_ren_i    = 1'b1;
    bus.mem_araddr_i = 32'h0000_00A0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 256'(bus.busy_o), 256'(0));
    chk("mid_rst_rvalid", 256'(bus.mem_rvalid_o), 256'(0));
    chk("mid_rst_rdata", bus.mem_rdata_o, 256'h0);
    chk("mid_rst_cnts", 256'({bus.rd_cnt_o, bus.wr_cnt_o}), 256'(0));
    bus.mem_ren_i = 1'b0;
    k = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_rvalid_o) k++;
    end
    chk("mid_rst_no_pulse", 256'(k), 256'(0));
    $display("reset mid-read busy=%0d rvalid_seen=%0d", bus.busy_o, k);
    rst = 1'b1;
    @(negedge clk);
    do_read("post_rst", 32'h0000_00A0, 256'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
